// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : MEM-stage data-memory access controller. Turns MemRead/MemWrite
//            plus funct3 into word-aligned memory requests with byte strobes.
//            It formats load data with sign or zero extension, and holds the
//            pipeline stalled until the memory acknowledges or times out.
// Params   : TIMEOUT - max BUSY cycles waiting for mem_ready (bus error after)
//            ADDR_W  - address width
// Ports    : clk, reset (async, active-high)
//            mem_read, mem_write, funct3, addr, wdata  - from EX/MEM
//            load_data (registered), stall (combinational) - to core
//            mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata - to memory
//            mem_rdata, mem_ready                          - from memory
//            illegal_op (1-cycle pulse), bus_error (sticky)
//            misaligned (1-cycle pulse, only with MISALIGN_TRAP_EN)
// Macro    : MISALIGN_TRAP_EN - trap misaligned H/W accesses as illegal
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              illegal_op,
    output logic              bus_error
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    localparam int           c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [1:0]   c_idle = 2'd0;
    localparam logic [1:0]   c_busy = 2'd1;
    localparam logic [1:0]   c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_lane;
    logic [2:0]         r_funct3;

    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [3:0]         r_mem_wstrb;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_load_data;
    logic               r_illegal_op;
    logic               r_bus_error;

    logic               w_access;
    logic               w_legal_f3;
    logic               w_misalign;
    logic               w_illegal;
    logic               w_start;
    logic               w_timeout;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_fmt;

    assign w_access = mem_read | mem_write;

    // Byte/half unsigned encodings exist only for loads; a store using them
    // (including the read+write case, which counts as a store) is illegal.
    always_comb begin
        w_legal_f3 = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal_f3 = 1'b1;
            3'b100, 3'b101:         w_legal_f3 = ~mem_write;
            default:                w_legal_f3 = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // funct3[1:0] is the access size: 01 = half, 10 = word.
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_illegal = w_access & (~w_legal_f3 | w_misalign);
    assign w_start   = (r_state == c_idle) & w_access & ~w_illegal;
    assign w_timeout = (r_cnt == c_cnt_last);

    // Stall is raised in the accepting IDLE cycle itself so the pipeline
    // holds the instruction while the request is launched.
    assign stall = ~reset & (w_start | (r_state == c_busy));

    // Store lane steering; low address bits below the access size are ignored.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = wdata;
            end
        endcase
        if (!mem_write) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load extraction uses the lane and size captured at request time.
    always_comb begin
        w_byte     = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half     = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_fmt = mem_rdata;
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_start) w_state_nxt = c_busy;
            c_busy:  if (mem_ready || w_timeout) w_state_nxt = c_done;
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_idle;
            r_cnt        <= '0;
            r_lane       <= 2'b00;
            r_funct3     <= 3'b000;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wstrb  <= 4'b0000;
            r_mem_wdata  <= 32'd0;
            r_load_data  <= 32'd0;
            r_illegal_op <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_illegal_op <= (r_state == c_idle) & w_illegal;
            case (r_state)
                c_idle: begin
                    if (w_start) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= mem_write;
                        r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        r_mem_wstrb <= w_wstrb;
                        r_mem_wdata <= w_wdata;
                        r_cnt       <= '0;
                        r_lane      <= addr[1:0];
                        r_funct3    <= funct3;
                    end else if (w_illegal) begin
                        r_load_data <= 32'd0;
                    end
                end
                c_busy: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_load_data <= w_load_fmt;
                        end
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_load_data <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= (r_state == c_idle) & w_access & w_misalign;
        end
    end

    assign misaligned = r_misaligned;
`endif

    assign load_data  = r_load_data;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wstrb  = r_mem_wstrb;
    assign mem_wdata  = r_mem_wdata;
    assign illegal_op = r_illegal_op;
    assign bus_error  = r_bus_error;

endmodule
`default_nettype wire
